inst_fetch: RTL

Instruction fetch stage for the KGP RISC pipeline.
- Holds the 10-bit word-addressed PC and issues reads to the synchronous instruction memory.
- Delivers {instruction, next-PC} pairs into the IF/ID pipeline register through a valid/ready handshake, using a 2-entry skid FIFO.
- Accepts branch/jump redirects from later stages, which flush every stale fetch.

---
 rtl/inst_fetch_if.sv | 25 ++
 rtl/inst_fetch.sv | 119 +++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch-stage bus: imem read port, redirect input, IF/ID output handshake
interface inst_fetch_if #(
  parameter int PC_W   = 10,
  parameter int INST_W = 32
);
  logic              imem_en;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] instOut;
  logic [PC_W-1:0]   NPCOut;

  modport master (
    output imem_en, imem_addr, out_valid, instOut, NPCOut,
    input  imem_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_en, imem_addr, out_valid, instOut, NPCOut,
    output imem_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - KGP instruction fetch: PC, imem read issue, 2-entry skid FIFO into IF/ID
// The FIFO head doubles as the registered output; a redirect flushes the in-flight read and the FIFO.
module inst_fetch #(
  parameter int              PC_W     = 10,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          reset,
  inst_fetch_if.master bus
);
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [PC_W-1:0]   pend_npc_q, pend_npc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [INST_W-1:0] head_inst_q, head_inst_d;
  logic [PC_W-1:0]   head_npc_q, head_npc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]   skid_npc_q, skid_npc_d;

  logic       xfer;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  // A read is only issued when its response is guaranteed a FIFO slot.
  assign xfer      = out_valid_q & bus.out_ready;
  assign push      = pend_q & ~bus.redirect;
  assign occupancy = {1'b0, cnt_q} + {2'b00, pend_q};
  assign issue     = ~bus.redirect & ((occupancy < 3'd2) | xfer);

  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.instOut   = head_inst_q;
  assign bus.NPCOut    = head_npc_q;

  always_comb begin
    pc_d        = pc_q;
    pend_d      = 1'b0;
    pend_npc_d  = pend_npc_q;
    cnt_d       = cnt_q;
    head_inst_d = head_inst_q;
    head_npc_d  = head_npc_q;
    skid_inst_d = skid_inst_q;
    skid_npc_d  = skid_npc_q;

    if (bus.redirect) begin
      pc_d  = bus.redirect_pc;
      cnt_d = 2'd0;
    end else begin
      if (issue) begin
        pc_d       = pc_q + PC_W'(1);
        pend_d     = 1'b1;
        pend_npc_d = pc_q + PC_W'(1);
      end

      unique case ({push, xfer})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_inst_d = bus.imem_data;
            head_npc_d  = pend_npc_q;
          end else begin
            skid_inst_d = bus.imem_data;
            skid_npc_d  = pend_npc_q;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          // Pop and push together: occupancy is unchanged.
          if (cnt_q == 2'd2) begin
            head_inst_d = skid_inst_q;
            head_npc_d  = skid_npc_q;
            skid_inst_d = bus.imem_data;
            skid_npc_d  = pend_npc_q;
          end else begin
            head_inst_d = bus.imem_data;
            head_npc_d  = pend_npc_q;
          end
        end
        2'b01: begin
          if (cnt_q == 2'd2) begin
            head_inst_d = skid_inst_q;
            head_npc_d  = skid_npc_q;
          end
          cnt_d = cnt_q - 2'd1;
        end
        default: ;
      endcase
    end

    out_valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_npc_q  <= '0;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      head_inst_q <= '0;
      head_npc_q  <= '0;
      skid_inst_q <= '0;
      skid_npc_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_npc_q  <= pend_npc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      head_inst_q <= head_inst_d;
      head_npc_q  <= head_npc_d;
      skid_inst_q <= skid_inst_d;
      skid_npc_q  <= skid_npc_d;
    end
  end
endmodule
